// File: rtl/seq_fsm_scheduler.sv
// Round-robin scheduler time-sharing one 2-bit sequence-detector engine across NUM_CH channel contexts.
// Optional per-channel saturating hit counters when SEQ_SCHED_HITCNT_EN is defined.
module seq_fsm_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] a_in,
  input  logic [NUM_CH-1:0] c_in,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] gnt,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_y,
  output logic [NUM_CH-1:0] busy_ch
`ifdef SEQ_SCHED_HITCNT_EN
  ,
  output logic [NUM_CH*8-1:0] hit_cnt
`endif
);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } st_e;

  st_e             st_q [NUM_CH];
  st_e             st_d [NUM_CH];
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic            out_y_q;

  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  st_e               s_sel;
  logic              y_d;

  function automatic st_e next_st(input st_e s, input logic a);
    case (s)
      S00:     next_st = a ? S01 : S00;
      S01:     next_st = a ? S01 : S11;
      S10:     next_st = a ? S10 : S00;
      default: next_st = a ? S10 : S11;
    endcase
  endfunction

  // Handshake: req[i] is held until gnt[i]; a cycle with req[i] & gnt[i] consumes
  // exactly one (a_in[i], c_in[i]) symbol at the closing edge. A cleared channel is ineligible.
  assign elig = req & ~clr;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (int'(ptr_q) + off) % NUM_CH;
      if (!gnt_any && elig[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = CH_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Mealy output is taken from the granted channel's state before its update.
  assign s_sel = st_q[gnt_idx];
  assign y_d   = (s_sel == S11) | ((s_sel == S10) & c_in[gnt_idx]);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i] = st_q[i];
      if (clr[i])      st_d[i] = S00;
      else if (gnt[i]) st_d[i] = next_st(st_q[i], a_in[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= S00;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_y_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= st_d[i];
      ptr_q       <= ptr_d;
      out_valid_q <= gnt_any;
      if (gnt_any) out_ch_q <= gnt_idx;
      out_y_q     <= gnt_any & y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_y     = out_y_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) busy_ch[i] = (st_q[i] != S00);
  end

`ifdef SEQ_SCHED_HITCNT_EN
  logic [7:0] hit_q [NUM_CH];
  logic [7:0] hit_d [NUM_CH];

  // Counts registered hits, so a hit is seen one edge after the result appears.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit_d[i] = hit_q[i];
      if (clr[i]) hit_d[i] = 8'd0;
      else if (out_valid_q && out_y_q && (out_ch_q == CH_W'(i)) && (hit_q[i] != 8'hFF))
        hit_d[i] = hit_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) hit_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) hit_q[i] <= hit_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) hit_cnt[i*8 +: 8] = hit_q[i];
  end
`endif

endmodule

// File: tb/tb_seq_fsm_scheduler.sv
// Directed self-checking bench for seq_fsm_scheduler (NUM_CH = 4); hit counter steps run
// only when SEQ_SCHED_HITCNT_EN is defined.
module tb_seq_fsm_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req, a_in, c_in, clr;
  logic [3:0] gnt;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_y;
  logic [3:0] busy_ch;
`ifdef SEQ_SCHED_HITCNT_EN
  logic [31:0] hit_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_fsm_scheduler #(.NUM_CH(4), .CH_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .c_in      (c_in),
    .clr       (clr),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_y     (out_y),
    .busy_ch   (busy_ch)
`ifdef SEQ_SCHED_HITCNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol set mid-cycle, check the combinational grant, then step past the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] a,
                     input logic [3:0] c, input logic [3:0] cl, input logic [3:0] exp_gnt);
    req  = r;
    a_in = a;
    c_in = c;
    clr  = cl;
    #2;
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch,
                         input logic y, input logic [3:0] busy);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
    chk({tag, "_y"}, 32'(out_y), 32'(y));
    chk({tag, "_busy"}, 32'(busy_ch), 32'(busy));
  endtask

  initial begin
    bit a2 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit y2 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    req = '0; a_in = '0; c_in = '0; clr = '0;
    #3;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy_ch), 0);
`ifdef SEQ_SCHED_HITCNT_EN
    chk("rst_hit", hit_cnt, 0);
`endif
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round robin across all four channels, results one cycle behind grants.
    for (int i = 0; i < 8; i++) begin
      cyc("rr", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'(1 << (i % 4)));
      chk_out("rr", 1'b1, 2'(i % 4), 1'b0, 4'b0000);
    end
    cyc("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("idle_valid", 32'(out_valid), 0);

    // Channel 2 walks 00->01->11->11->10->10.
    for (int i = 0; i < 5; i++) begin
      cyc("ch2", 4'b0100, {1'b0, a2[i], 2'b00}, 4'b0000, 4'b0000, 4'b0100);
      chk_out("ch2", 1'b1, 2'd2, y2[i], 4'b0100);
    end

    // Channel 1 to state 10, then exercise the C qualifier.
    cyc("ch1a", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    chk_out("ch1a", 1'b1, 2'd1, 1'b0, 4'b0110);
    cyc("ch1b", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    chk_out("ch1b", 1'b1, 2'd1, 1'b0, 4'b0110);
    cyc("ch1c", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    chk_out("ch1c", 1'b1, 2'd1, 1'b1, 4'b0110);
    cyc("ch1_c1", 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    chk_out("ch1_c1", 1'b1, 2'd1, 1'b1, 4'b0110);
    cyc("ch1_c0", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    chk_out("ch1_c0", 1'b1, 2'd1, 1'b0, 4'b0110);

    // Pointer is 2: only channel 0 eligible while 1 and 2 are cleared.
    cyc("clr12", 4'b0001, 4'b0001, 4'b0000, 4'b0110, 4'b0001);
    chk_out("clr12", 1'b1, 2'd0, 1'b0, 4'b0001);
    cyc("ch3", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    chk_out("ch3", 1'b1, 2'd3, 1'b0, 4'b0001);

    // Pointer 0, req 0101 with clr on channel 0: grant skips to channel 2.
    cyc("clr0", 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0100);
    chk_out("clr0", 1'b1, 2'd2, 1'b0, 4'b0000);
    cyc("ptr3", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    chk_out("ptr3", 1'b1, 2'd3, 1'b0, 4'b0000);

    // Channel 3 to state 11, then reset mid-stream.
    cyc("c3a", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    chk_out("c3a", 1'b1, 2'd3, 1'b0, 4'b1000);
    cyc("c3b", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    chk_out("c3b", 1'b1, 2'd3, 1'b0, 4'b1000);
    req = 4'b1111; a_in = '0; c_in = '0; clr = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_ch", 32'(out_ch), 0);
    chk("mrst_busy", 32'(busy_ch), 0);
    @(posedge clk);
    #1;
    chk("mrst_hold_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    cyc("post_rst", 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    chk_out("post_rst", 1'b1, 2'd1, 1'b0, 4'b0000);

`ifdef SEQ_SCHED_HITCNT_EN
    // Channel 0 to state 11, then 270 symbols with a=0 each giving Y=1.
    cyc("h_a", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cyc("h_b", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    chk("hit_start", hit_cnt, 0);
    for (int j = 0; j < 270; j++) begin
      cyc("hit", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      if (j == 9) chk("hit_mid", 32'(hit_cnt[7:0]), 9);
    end
    cyc("hit_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("hit_sat", 32'(hit_cnt[7:0]), 255);
    cyc("hit_clr", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    chk("hit_clr", 32'(hit_cnt[7:0]), 0);
    chk("hit_clr_busy", 32'(busy_ch), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
